// File: rtl/vectored_irq_ctrl.sv
// Vectored priority interrupt controller: synchronised request lines, per-channel
// edge/level pending, fixed priority with in-service nesting, and a pend/ack handshake.
module vectored_irq_ctrl #(
    parameter int                 N_CH       = 4,
    parameter int                 A_WIDTH    = 8,
    parameter logic [A_WIDTH-1:0] VEC_BASE   = 8'hF0,
    parameter int                 VEC_STRIDE = 1,
    parameter int                 SYNC       = 2
) (
    input  logic                    g_clk,
    input  logic                    g_clr,
    input  logic [N_CH-1:0]         irq_in,
    input  logic [N_CH-1:0]         mask_in,
    input  logic [N_CH-1:0]         edge_sel,
    input  logic                    i_en,
    input  logic                    i_ack,
    input  logic                    i_eoi,
    output logic                    i_pending,
    output logic [A_WIDTH-1:0]      vec_out,
    output logic [$clog2(N_CH)-1:0] ch_id,
    output logic [N_CH-1:0]         in_service
);

    localparam int IW = $clog2(N_CH);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [N_CH-1:0]    irq_sync;
    logic [N_CH-1:0]    hist_reg;
    logic [N_CH-1:0]    rise;
    logic [N_CH-1:0]    epend_reg, epend_next;
    logic [N_CH-1:0]    pend;
    logic [N_CH-1:0]    above_isr;
    logic [N_CH-1:0]    qual;
    logic [N_CH-1:0]    isr_reg, isr_next;
    logic [N_CH-1:0]    eoi_clr, ack_set, ack_clr;
    logic               ack_take;
    logic               any_qual;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      ch_id_reg;
    logic [A_WIDTH-1:0] vec_reg, vec_calc;

    generate
        if (SYNC == 0) begin : g_nosync
            assign irq_sync = irq_in;
        end else begin : g_sync
            logic [N_CH-1:0] sync_reg [SYNC];
            always_ff @(posedge g_clk or posedge g_clr) begin
                if (g_clr) begin
                    for (int i = 0; i < SYNC; i++) sync_reg[i] <= '0;
                end else begin
                    sync_reg[0] <= irq_in;
                    for (int i = 1; i < SYNC; i++) sync_reg[i] <= sync_reg[i-1];
                end
            end
            assign irq_sync = sync_reg[SYNC-1];
        end
    endgenerate

    // Edge pending only arms in edge mode; a same-cycle edge beats the ack clear.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rise[gi]       = irq_sync[gi] & ~hist_reg[gi];
            assign epend_next[gi] = (rise[gi] & edge_sel[gi]) | (epend_reg[gi] & ~ack_clr[gi]);
            assign pend[gi]       = edge_sel[gi] ? epend_reg[gi] : irq_sync[gi];
            assign above_isr[gi]  = ~|isr_reg[gi:0];
        end
    endgenerate

    assign qual     = pend & mask_in & {N_CH{i_en}} & above_isr;
    assign any_qual = |qual;

    always_comb begin
        win_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (qual[i]) win_idx = IW'(i);
        end
    end

    assign vec_calc = VEC_BASE + A_WIDTH'(int'(win_idx) * VEC_STRIDE);

    assign ack_take = (state_reg == PEND) && i_ack;
    assign ack_set  = ack_take ? (N_CH'(1) << ch_id_reg) : '0;
    assign ack_clr  = ack_set & edge_sel;
    // Lowest set bit of the in-service register is the most recent nesting level.
    assign eoi_clr  = i_eoi ? (isr_reg & (~isr_reg + N_CH'(1))) : '0;
    assign isr_next = (isr_reg & ~eoi_clr) | ack_set;

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) begin
            hist_reg  <= '0;
            epend_reg <= '0;
            isr_reg   <= '0;
            ch_id_reg <= '0;
            vec_reg   <= '0;
        end else begin
            hist_reg  <= irq_sync;
            epend_reg <= epend_next;
            isr_reg   <= isr_next;
            if (state_reg == IDLE && any_qual) begin
                ch_id_reg <= win_idx;
                vec_reg   <= vec_calc;
            end
        end
    end

    always_ff @(posedge g_clk or posedge g_clr) begin
        if (g_clr) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (any_qual) state_next = PEND;
            PEND: begin
                if (i_ack)                   state_next = IDLE;
                else if (!qual[ch_id_reg])   state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        i_pending  = (state_reg == PEND);
        ch_id      = ch_id_reg;
        vec_out    = vec_reg;
        in_service = isr_reg;
    end

endmodule

// File: tb/tb_vectored_irq_ctrl.sv
// Self-checking bench: 4-channel table with a scoreboard queue, plus a 16-channel
// hand sequence for vector wrap and asynchronous reset in PEND.
module tb_vectored_irq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, ack_a, eoi_a, pend_a;
    logic [3:0] irq_a, mask_a, edge_a, isr_a;
    logic [7:0] vec_a;
    logic [1:0] ch_a;

    logic        rst_b, en_b, ack_b, eoi_b, pend_b;
    logic [15:0] irq_b, mask_b, edge_b, isr_b;
    logic [7:0]  vec_b;
    logic [3:0]  ch_b;

    int errors = 0;
    int checks = 0;

    vectored_irq_ctrl #(.N_CH(4), .A_WIDTH(8), .VEC_BASE(8'hF0), .VEC_STRIDE(1), .SYNC(2)) dut_a (
        .g_clk(clk), .g_clr(rst_a), .irq_in(irq_a), .mask_in(mask_a), .edge_sel(edge_a),
        .i_en(en_a), .i_ack(ack_a), .i_eoi(eoi_a), .i_pending(pend_a), .vec_out(vec_a),
        .ch_id(ch_a), .in_service(isr_a)
    );

    vectored_irq_ctrl #(.N_CH(16), .A_WIDTH(8), .VEC_BASE(8'hF8), .VEC_STRIDE(1), .SYNC(2)) dut_b (
        .g_clk(clk), .g_clr(rst_b), .irq_in(irq_b), .mask_in(mask_b), .edge_sel(edge_b),
        .i_en(en_b), .i_ack(ack_b), .i_eoi(eoi_b), .i_pending(pend_b), .vec_out(vec_b),
        .ch_id(ch_b), .in_service(isr_b)
    );

    typedef struct {
        string      name;
        logic [3:0] irq;
        logic [3:0] mask;
        logic [3:0] edg;
        logic       ack;
        logic       eoi;
        logic       exp_pend;
        logic [7:0] exp_vec;
        logic [1:0] exp_ch;
        logic [3:0] exp_isr;
    } step_t;

    step_t tbl[$];
    step_t exp_q[$];

    task automatic add(string nm, logic [3:0] irq, logic [3:0] mask, logic [3:0] edg,
                       logic ack, logic eoi, logic p, logic [7:0] v, logic [1:0] c, logic [3:0] isr);
        step_t s;
        s.name = nm; s.irq = irq; s.mask = mask; s.edg = edg; s.ack = ack; s.eoi = eoi;
        s.exp_pend = p; s.exp_vec = v; s.exp_ch = c; s.exp_isr = isr;
        tbl.push_back(s);
    endtask

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t e;

        // name, irq, mask, edge, ack, eoi, pend, vec, ch, isr
        add("t1_req",   4'b0100, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t1_sync",  4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t1_edge",  4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t1_pres",  4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF2, 2, 4'h0);
        add("t1_hold",  4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF2, 2, 4'h0);
        add("t1_ack",   4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h4);
        add("t3_req",   4'b0001, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("t3_w1",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("t3_w2",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("t3_pres",  4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF0, 0, 4'h4);
        add("t3_ack",   4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h5);
        add("t3_eoi1",  4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h4);
        add("t3_eoi2",  4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("eoi_empty",4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t2_req",   4'b1010, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t2_w1",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t2_w2",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t2_pres1", 4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("t2_ack1",  4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h2);
        add("t2_held1", 4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h2);
        add("t2_held2", 4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h2);
        add("t2_eoi",   4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t2_pres3", 4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF3, 3, 4'h0);
        add("t2_ack3",  4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h8);
        add("t2_eoi3",  4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t4_req",   4'b0010, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t4_w1",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t4_w2",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t4_pres",  4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("t4_mask",  4'b0000, 4'hD, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t4_masked",4'b0000, 4'hD, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t4_unmask",4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("t4_ack",   4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h2);
        add("t4_eoi",   4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t5_lvl",   4'b0001, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t5_w1",    4'b0001, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h0);
        add("t5_pres",  4'b0001, 4'hF, 4'hE, 0, 0, 1, 8'hF0, 0, 4'h0);
        add("t5_ack",   4'b0001, 4'hF, 4'hE, 1, 0, 0, 8'h00, 0, 4'h1);
        add("t5_isr",   4'b0001, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h1);
        add("t5_eoi",   4'b0001, 4'hF, 4'hE, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t5_repres",4'b0001, 4'hF, 4'hE, 0, 0, 1, 8'hF0, 0, 4'h0);
        add("t5_ack2",  4'b0001, 4'hF, 4'hE, 1, 0, 0, 8'h00, 0, 4'h1);
        add("t5_drop",  4'b0000, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h1);
        add("t5_dropw", 4'b0000, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h1);
        add("t5_eoi2",  4'b0000, 4'hF, 4'hE, 0, 1, 0, 8'h00, 0, 4'h0);
        add("t5_gone",  4'b0000, 4'hF, 4'hE, 0, 0, 0, 8'h00, 0, 4'h0);
        add("sw_req1",  4'b0010, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("sw_w1",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("sw_w2",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("sw_req2",  4'b0010, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("sw_w3",    4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("sw_ackedge",4'b0000,4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h2);
        add("sw_eoi",   4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("sw_repres",4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF1, 1, 4'h0);
        add("sw_ack",   4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h2);
        add("sw_eoi2",  4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("sw_idle",  4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("ae_req2",  4'b0100, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("ae_w1",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("ae_w2",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h0);
        add("ae_pres2", 4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF2, 2, 4'h0);
        add("ae_ack2",  4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h4);
        add("ae_req0",  4'b0001, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("ae_w3",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("ae_w4",    4'b0000, 4'hF, 4'hF, 0, 0, 0, 8'h00, 0, 4'h4);
        add("ae_pres0", 4'b0000, 4'hF, 4'hF, 0, 0, 1, 8'hF0, 0, 4'h4);
        add("ae_ackeoi",4'b0000, 4'hF, 4'hF, 1, 1, 0, 8'h00, 0, 4'h1);
        add("ae_eoi",   4'b0000, 4'hF, 4'hF, 0, 1, 0, 8'h00, 0, 4'h0);
        add("ack_idle", 4'b0000, 4'hF, 4'hF, 1, 0, 0, 8'h00, 0, 4'h0);

        rst_a = 1'b1; irq_a = '0; mask_a = 4'hF; edge_a = 4'hF; en_a = 1'b1; ack_a = 1'b0; eoi_a = 1'b0;
        rst_b = 1'b1; irq_b = '0; mask_b = 16'hFFFF; edge_b = 16'hFFFF; en_b = 1'b1; ack_b = 1'b0; eoi_b = 1'b0;
        #2;
        check("rst_a_pend", 32'(pend_a), 32'h0);
        check("rst_a_vec",  32'(vec_a),  32'h0);
        check("rst_a_ch",   32'(ch_a),   32'h0);
        check("rst_a_isr",  32'(isr_a),  32'h0);
        check("rst_b_pend", 32'(pend_b), 32'h0);
        check("rst_b_isr",  32'(isr_b),  32'h0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            irq_a = tbl[i].irq; mask_a = tbl[i].mask; edge_a = tbl[i].edg;
            ack_a = tbl[i].ack; eoi_a = tbl[i].eoi;
            exp_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("step %0d %s pend=%0b vec=%02h ch=%0d isr=%04b", i + 1, e.name, pend_a, vec_a, ch_a, isr_a);
            check({e.name, "_pend"}, 32'(pend_a), 32'(e.exp_pend));
            check({e.name, "_isr"},  32'(isr_a),  32'(e.exp_isr));
            if (e.exp_pend) begin
                check({e.name, "_vec"}, 32'(vec_a), 32'(e.exp_vec));
                check({e.name, "_ch"},  32'(ch_a),  32'(e.exp_ch));
            end
        end
        ack_a = 1'b0; eoi_a = 1'b0; irq_a = '0;

        // 16-channel instance: vector wrap, then async reset while presenting.
        irq_b = 16'h1000;
        tick_b();
        irq_b = '0;
        tick_b(); tick_b();
        check("b_no_pend_e3", 32'(pend_b), 32'h0);
        tick_b();
        $display("b ch12 pend=%0b vec=%02h ch=%0d", pend_b, vec_b, ch_b);
        check("b_pend_e4", 32'(pend_b), 32'h1);
        check("b_vec_wrap", 32'(vec_b), 32'h04);
        check("b_ch12", 32'(ch_b), 32'd12);
        ack_b = 1'b1;
        tick_b();
        ack_b = 1'b0;
        $display("b ack pend=%0b isr=%04h", pend_b, isr_b);
        check("b_ack_pend", 32'(pend_b), 32'h0);
        check("b_ack_isr", 32'(isr_b), 32'h1000);
        irq_b = 16'h0008;
        tick_b();
        irq_b = '0;
        tick_b(); tick_b(); tick_b();
        $display("b ch3 pend=%0b vec=%02h ch=%0d", pend_b, vec_b, ch_b);
        check("b_pend_ch3", 32'(pend_b), 32'h1);
        check("b_vec_ch3", 32'(vec_b), 32'hFB);
        #1;
        rst_b = 1'b1;
        #1;
        $display("b reset pend=%0b vec=%02h isr=%04h", pend_b, vec_b, isr_b);
        check("b_rst_pend", 32'(pend_b), 32'h0);
        check("b_rst_isr", 32'(isr_b), 32'h0);
        check("b_rst_vec", 32'(vec_b), 32'h0);
        check("b_rst_ch", 32'(ch_b), 32'h0);
        tick_b();
        rst_b = 1'b0;
        tick_b(); tick_b(); tick_b(); tick_b();
        check("b_post_rst_pend", 32'(pend_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vectored_irq_ctrl.md
# vectored_irq_ctrl

Parametrised hardware vector priority interrupt controller, the successor to the fixed 4-line interrupt system in the processor's stage-one fetch path. It handles `N_CH` request lines and gives each channel a selectable edge or level mode, a per-channel enable mask, fixed priority with nesting through an in-service register, and a pending/acknowledge handshake with the controller. The controller loads `vec_out` into the PC mux on acknowledge and pulses `i_eoi` on return-from-interrupt.

## Interface

- `N_CH`, 4: number of interrupt channels; 2..16.
- `A_WIDTH`, 8: vector/PC width.
- `VEC_BASE`, 8'hF0: vector of channel 0.
- `VEC_STRIDE`, 1: vector spacing between channels.
- `SYNC`, 2: input synchroniser depth; 0 means inputs are already synchronous.

- `g_clk`, in, 1: clock; all state changes on the rising edge.
- `g_clr`, in, 1: reset; asynchronous, active-high.
- `irq_in`, in, `N_CH`: request lines.
- `mask_in`, in, `N_CH`: 1 enables the channel.
- `edge_sel`, in, `N_CH`: 1 selects rising-edge mode, 0 selects level mode.
- `i_en`, in, 1: global interrupt enable.
- `i_ack`, in, 1: one-cycle acknowledge from the controller.
- `i_eoi`, in, 1: one-cycle end-of-interrupt.
- `i_pending`, out, 1: request to the controller.
- `vec_out`, out, `A_WIDTH`: vector of the presented channel.
- `ch_id`, out, `$clog2(N_CH)`: index of the presented channel.
- `in_service`, out, `N_CH`: in-service register, for debug.

## Operation

**Reset values**
- All sync flops, edge-history, pending and in-service bits are 0.
- FSM is in IDLE.
- `i_pending`=0, `vec_out`=0, `ch_id`=0.

**Input path**
- Each `irq_in` bit passes through `SYNC` flops, then the edge detector.
- Edge history resets to 0, so a line held high through reset registers one edge after release.

**Pending bits**
- Edge mode: bit set on a synchronised rising edge. Cleared only when that channel is acknowledged. If set and clear occur in the same cycle, set wins.
- Level mode: pending equals the synchronised level. Ack does not clear it; the source must drop the line.

**Qualification**
- A channel qualifies when pending & `mask_in` & `i_en` are all true.
- It must also have strictly higher priority than the highest-priority in-service bit.
- Priority is fixed: index 0 is highest.
- Winner = lowest-index qualified channel.

**Vector**
- `vec_out` = `VEC_BASE` + winner×`VEC_STRIDE`, truncated to `A_WIDTH` bits (wraps mod 2^A_WIDTH).

**FSM**
- IDLE:
  - If any channel qualifies, latch the winner into `ch_id`/`vec_out` and go to PEND.
  - `i_ack` is ignored.
- PEND:
  - `i_pending`=1 and `vec_out`/`ch_id` are frozen. A higher-priority arrival does not change the presented vector.
  - On `i_ack`: set in-service[ch_id], clear pending[ch_id] if that channel is edge mode, go to IDLE.
  - Without `i_ack`: if the latched channel no longer qualifies (masked, `i_en` low, or level line dropped), withdraw to IDLE.
  - `i_ack` takes precedence over withdrawal in the same cycle.

**EOI**
- `i_eoi` clears the highest-priority set in-service bit.
- EOI with in-service empty is ignored.
- EOI and ack in the same cycle: EOI clears the old bit and ack sets the new bit; both take effect.

**Nesting**
- Depth up to `N_CH`. A lower-or-equal priority request waits until the EOI that exposes it.

**Reset mid-operation**
- Asynchronous return to the reset values above, including in PEND, with no further outputs.

## Timing

- Latency from `irq_in` rising (setup before edge 1) to `i_pending` high: `SYNC`+2 rising edges.
  - `SYNC`=2: `i_pending` rises after edge 4.
  - `SYNC`=0: `i_pending` rises after edge 2.
- `i_pending` is registered and falls after the edge that samples `i_ack`.
- Earliest re-assertion is one edge later. Minimum IDLE dwell between presentations is 1 cycle.
- Withdrawal: `i_pending` falls after the edge at which the disqualification is sampled.
- The in-service update from ack/EOI is visible to qualification on the following cycle.
- The `irq_in` level-mode drop reaches pending after `SYNC` edges.
- Outputs are glitch-free: all are driven straight from flops.

## Test plan

1. **Basic vectoring.** `N_CH`=4, `SYNC`=2, all edge mode, all unmasked, `i_en`=1. Pulse `irq_in[2]` for one cycle. Required: `i_pending`=1 after edge 4, `vec_out`=8'hF2, `ch_id`=2. Ack clears `i_pending` next edge and sets `in_service`=4'b0100.
2. **Priority and nesting.** Raise `irq_in[3]` and `irq_in[1]` in the same cycle. Required: ch1 (8'hF1) is presented first. After ack, ch3 is held back until ch1's EOI, then presented as 8'hF3. After the second ack, `in_service`=4'b1000.
3. **Preemption.** With ch2 in service, pulse ch0. Required: ch0 is presented and acked, giving `in_service`=4'b0101. The first EOI clears bit 0 only.
4. **Withdrawal.** While in PEND on ch1, drop `mask_in[1]` with no ack. Required: `i_pending` is 0 next edge, pending[1] stays 1 (edge mode), and ch1 is re-presented when unmasked.
5. **Level mode and same-cycle ack.** Set `edge_sel[0]`=0 and hold `irq_in[0]` high. Ack, then EOI with the line still high. Required: re-presented `SYNC`-independently 1 edge after EOI. A new edge on an edge-mode channel in the ack cycle stays pending.
6. **Vector wrap and reset mid-PEND.** `N_CH`=16, `VEC_BASE`=8'hF8, request ch12. Required: `vec_out`=8'h04. Asserting `g_clr` mid-PEND forces `i_pending`=0 and `in_service`=0 immediately, without waiting for a clock.
